midi_transmitter: RTL and testbench

- Serialises MIDI bytes onto a single TX line: 31250 baud, 8N1, LSB first, line idles high.
- It is the output-direction counterpart to midi_receiver. It sits between a byte producer (sequencer/controller logic) and the MIDI OUT pin.
- Bytes enter through a valid/ready handshake and are buffered in a small FIFO so multi-byte messages go out back-to-back.

---
 rtl/midi_transmitter.sv | 169 ++++++++++++++++
 tb/tb_midi_transmitter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_transmitter.sv
// MIDI OUT serialiser: 8N1, LSB first, idle-high line.
// Bytes are taken on a valid/ready handshake into a small circular FIFO so
// multi-byte messages leave as back-to-back frames with no idle gap.
module midi_transmitter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       valid,
    output logic       ready,
    output logic       dout,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int COUNT_W      = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("midi_transmitter: CLK_FREQ/BAUD must be at least 2");
    end

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("midi_transmitter: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               ready_q;

    state_t             state_q;
    logic [CNT_W-1:0]   baud_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               dout_q;
    logic               busy_q;

    logic               push;
    logic               pop;
    logic               load_slot;
    logic               cell_end;

    // ready_q already encodes "not full", so a push can never overflow.
    assign push      = valid && ready_q;
    assign cell_end  = (baud_q == CNT_LAST);
    // The shifter can take a new byte while idle or on the last cycle of a stop cell.
    assign load_slot = (state_q == IDLE) || ((state_q == STOP) && cell_end);
    assign pop       = load_slot && (count_q != '0);

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q + COUNT_W'(push) - COUNT_W'(pop);
    end

    // FIFO storage holds data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // FIFO pointers, occupancy and ready; ready tracks the next occupancy so it
    // is exactly !full every cycle without a path from valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != COUNT_FULL);
        end
    end

    // Frame state machine; dout is driven from the state of the previous cycle
    // so every bit cell on the line is exactly CLKS_PER_BIT cycles long.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dout_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE) || (count_q != '0);
            case (state_q)
                IDLE: begin
                    dout_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    dout_q <= 1'b0;
                    if (cell_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    dout_q <= shift_q[bit_idx_q];
                    if (cell_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    dout_q <= 1'b1;
                    if (cell_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                default: begin
                    dout_q  <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign dout  = dout_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_midi_transmitter.sv
// Directed bench for midi_transmitter with CLKS_PER_BIT = 16 and a
// loopback MIDI receiver model on the TX line.
module tb_midi_transmitter;
    localparam int CPB  = 16;
    localparam int LOGN = 8192;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] din   = 8'h00;
    logic       ready;
    logic       dout;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic dlog [LOGN];
    logic blog [LOGN];
    logic rlog [LOGN];

    int         acc_n = 0;
    int         acc_edge [64];
    logic [7:0] acc_byte [64];

    int         rx_st   = 0;
    int         rx_cnt  = 0;
    int         rx_ferr = 0;
    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] rx_q [$];

    midi_transmitter #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .valid(valid),
        .ready(ready),
        .dout (dout),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Edge counter, accepted-byte log, and post-edge output log indexed by edge number.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (valid && ready && reset && acc_n < 64) begin
            acc_edge[acc_n] = cyc;
            acc_byte[acc_n] = din;
            acc_n = acc_n + 1;
        end
        #2;
        if (cyc < LOGN) begin
            dlog[cyc] = dout;
            blog[cyc] = busy;
            rlog[cyc] = ready;
        end
    end

    // Loopback receiver: samples mid-cell, checks start and stop bits.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st  = 0;
            rx_cnt = 0;
        end else if (rx_st == 0) begin
            if (dout === 1'b0) begin
                rx_st  = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt = rx_cnt + 1;
            if (rx_cnt == CPB / 2) begin
                if (dout !== 1'b0) rx_st = 0;
            end else if (rx_cnt > CPB / 2 && rx_cnt < CPB / 2 + 9 * CPB &&
                         ((rx_cnt - CPB / 2) % CPB) == 0) begin
                rx_sh[(rx_cnt - CPB / 2) / CPB - 1] = dout;
            end else if (rx_cnt == CPB / 2 + 9 * CPB) begin
                if (dout === 1'b1) rx_q.push_back(rx_sh);
                else rx_ferr = rx_ferr + 1;
                rx_st = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (dout !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold dout/busy/ready got %b%b%b want 100", dout, busy, ready);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_release got %b want 1", ready);
        end
        total++;
        if (dout !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release dout/busy got %b%b want 10", dout, busy);
        end
    endtask

    task automatic test_single();
        int         k;
        int         n0;
        logic       ok;
        logic [0:9] seq;
        seq = 10'b0000010011;
        rx_q.delete();
        n0 = acc_n;
        @(negedge clk);
        din = 8'h90; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (acc_n != n0 + 1) begin
            bad++;
            $display("FAIL single_accept got %0d accepts want 1", acc_n - n0);
        end
        k = acc_edge[n0];
        repeat (175) @(negedge clk);
        total++;
        if (dlog[k+1] !== 1'b1 || dlog[k+2] !== 1'b0) begin
            bad++;
            $display("FAIL single_start_edge dout@k+1,k+2 got %b%b want 10", dlog[k+1], dlog[k+2]);
        end
        for (int c = 0; c < 10; c++) begin
            ok = 1'b1;
            for (int j = 0; j < CPB; j++)
                if (dlog[k+2+c*CPB+j] !== seq[c] || blog[k+2+c*CPB+j] !== 1'b1) ok = 1'b0;
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL single_cell%0d dout got %b busy %b want %b busy 1",
                         c, dlog[k+2+c*CPB], blog[k+2+c*CPB], seq[c]);
            end
        end
        total++;
        if (blog[k+161] !== 1'b1 || blog[k+162] !== 1'b0 || dlog[k+162] !== 1'b1) begin
            bad++;
            $display("FAIL single_busy_drop busy@k+161,k+162 got %b%b want 10, dout %b want 1",
                     blog[k+161], blog[k+162], dlog[k+162]);
        end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h90) begin
            bad++;
            $display("FAIL single_loopback got %0d bytes first %h want 1 byte 90",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        int         k;
        int         n0;
        logic       ok;
        logic       exp;
        logic [7:0] msg [3];
        msg[0] = 8'h90; msg[1] = 8'h3C; msg[2] = 8'h64;
        rx_q.delete();
        n0 = acc_n;
        @(negedge clk);
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = msg[i];
            @(negedge clk);
        end
        valid = 1'b0;
        k = acc_edge[n0];
        total++;
        if (acc_n != n0 + 3 || acc_edge[n0+1] != k + 1 || acc_edge[n0+2] != k + 2) begin
            bad++;
            $display("FAIL b2b_accept got %0d accepts want 3 on consecutive edges", acc_n - n0);
        end
        repeat (495) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 10; c++) begin
                exp = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : msg[f][c-1];
                ok = 1'b1;
                for (int j = 0; j < CPB; j++)
                    if (dlog[k+2+(f*10+c)*CPB+j] !== exp) ok = 1'b0;
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL b2b_frame%0d_cell%0d dout got %b want %b",
                             f, c, dlog[k+2+(f*10+c)*CPB], exp);
                end
            end
        end
        total++;
        if (blog[k+481] !== 1'b1 || blog[k+482] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy_drop busy@k+481,k+482 got %b%b want 10", blog[k+481], blog[k+482]);
        end
        total++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h90 || rx_q[1] !== 8'h3C || rx_q[2] !== 8'h64) begin
            bad++;
            $display("FAIL b2b_loopback got %0d bytes want 90 3c 64", rx_q.size());
        end
    endtask

    task automatic test_fifo_full();
        int   k;
        int   n0;
        logic ok;
        rx_q.delete();
        n0 = acc_n;
        @(negedge clk);
        valid = 1'b1;
        din   = 8'h01;
        for (int g = 0; g < 2000 && (acc_n - n0) < 8; g++) begin
            @(negedge clk);
            din = 8'(acc_n - n0 + 1);
        end
        valid = 1'b0;
        total++;
        if (acc_n - n0 != 8) begin
            bad++;
            $display("FAIL full_total_accepts got %0d want 8", acc_n - n0);
        end
        k = acc_edge[n0];
        ok = 1'b1;
        for (int i = 0; i < 5; i++)
            if (acc_edge[n0+i] != k + i) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL full_first_five 5th accepted at k+%0d want k+4", acc_edge[n0+4] - k);
        end
        ok = 1'b1;
        for (int e = k + 4; e <= k + 160; e++)
            if (rlog[e] !== 1'b0) ok = 1'b0;
        total++;
        if (!ok || rlog[k+3] !== 1'b1) begin
            bad++;
            $display("FAIL full_ready_low ready@k+3 got %b want 1, low window ok=%b want 1", rlog[k+3], ok);
        end
        total++;
        if (rlog[k+161] !== 1'b1 || acc_edge[n0+5] != k + 162) begin
            bad++;
            $display("FAIL full_reassert ready@k+161 got %b want 1, 6th accept k+%0d want k+162",
                     rlog[k+161], acc_edge[n0+5] - k);
        end
        total++;
        if (acc_edge[n0+6] != k + 322 || acc_edge[n0+7] != k + 482) begin
            bad++;
            $display("FAIL full_later_accepts got k+%0d k+%0d want k+322 k+482",
                     acc_edge[n0+6] - k, acc_edge[n0+7] - k);
        end
        ok = 1'b1;
        for (int i = 0; i < 8; i++)
            if (acc_byte[n0+i] !== 8'(i + 1)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL full_accept_order first byte %h want 01 ascending", acc_byte[n0]);
        end
        for (int g = 0; g < 1000 && cyc < k + 1290; g++) @(negedge clk);
        total++;
        if (blog[k+1281] !== 1'b1 || blog[k+1282] !== 1'b0) begin
            bad++;
            $display("FAIL full_busy_drop busy@k+1281,k+1282 got %b%b want 10", blog[k+1281], blog[k+1282]);
        end
        ok = (rx_q.size() == 8);
        if (ok)
            for (int i = 0; i < 8; i++)
                if (rx_q[i] !== 8'(i + 1)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL full_loopback got %0d bytes want 01..08 in order", rx_q.size());
        end
    endtask

    task automatic test_push_pop();
        int         k;
        int         n0;
        logic       ok;
        logic       exp;
        logic [7:0] msg [3];
        msg[0] = 8'hA5; msg[1] = 8'h5A; msg[2] = 8'hC3;
        rx_q.delete();
        n0 = acc_n;
        @(negedge clk);
        valid = 1'b1; din = msg[0];
        @(negedge clk);
        din = msg[1];
        @(negedge clk);
        valid = 1'b0;
        k = acc_edge[n0];
        for (int g = 0; g < 400 && cyc < k + 160; g++) @(negedge clk);
        valid = 1'b1; din = msg[2];
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (acc_n != n0 + 3 || acc_edge[n0+2] != k + 161) begin
            bad++;
            $display("FAIL pp_push_edge third push at k+%0d want k+161", acc_edge[n0+2] - k);
        end
        for (int g = 0; g < 600 && cyc < k + 490; g++) @(negedge clk);
        ok = 1'b1;
        for (int f = 0; f < 3; f++)
            for (int c = 0; c < 10; c++) begin
                exp = (c == 0) ? 1'b0 : (c == 9) ? 1'b1 : msg[f][c-1];
                for (int j = 0; j < CPB; j++)
                    if (dlog[k+2+(f*10+c)*CPB+j] !== exp) ok = 1'b0;
            end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL pp_stream got non-contiguous or wrong frames want a5 5a c3 back to back");
        end
        ok = 1'b1;
        for (int e = k; e <= k + 481; e++)
            if (rlog[e] !== 1'b1) ok = 1'b0;
        total++;
        if (!ok || blog[k+481] !== 1'b1 || blog[k+482] !== 1'b0) begin
            bad++;
            $display("FAIL pp_count ready steady got %b want 1, busy@k+481,k+482 got %b%b want 10",
                     ok, blog[k+481], blog[k+482]);
        end
        total++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h5A || rx_q[2] !== 8'hC3) begin
            bad++;
            $display("FAIL pp_loopback got %0d bytes want a5 5a c3", rx_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int   k;
        int   n0;
        int   r;
        logic ok;
        rx_q.delete();
        n0 = acc_n;
        @(negedge clk);
        valid = 1'b1; din = 8'hF0;
        @(negedge clk);
        din = 8'h11;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        valid = 1'b0;
        k = acc_edge[n0];
        for (int g = 0; g < 200 && cyc < k + 70; g++) @(negedge clk);
        total++;
        if (dout !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit3 dout/busy got %b%b want 01", dout, busy);
        end
        reset = 1'b0;
        #1;
        total++;
        if (dout !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_async dout/busy/ready got %b%b%b want 100", dout, busy, ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        r = cyc;
        repeat (200) @(negedge clk);
        ok = 1'b1;
        for (int e = r + 1; e < r + 199; e++)
            if (dlog[e] !== 1'b1 || blog[e] !== 1'b0 || rlog[e] !== 1'b1) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_after_release dout/busy/ready first got %b%b%b want 101",
                     dlog[r+1], blog[r+1], rlog[r+1]);
        end
        total++;
        if (rx_q.size() != 0) begin
            bad++;
            $display("FAIL mid_residual got %0d bytes want 0", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_push_pop();
        test_reset_midframe();
        total++;
        if (rx_ferr != 0) begin
            bad++;
            $display("FAIL framing_errors got %0d want 0", rx_ferr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
